// File: rtl/sc_adder_chain_ctrl.sv
// Sequencer for a stochastic adder chain: flush, pipeline fill, timed run
// and ones-count of the chain output, plus the LFSR that drives the selects.
// Ports: clk, rst (async, active-low), start/abort/len control, sum_in
// bitstream in; sel, src_en, flush, busy, done, count out.
// Optional macro SC_CTRL_SEED_EN adds a 16-bit seed input.
module sc_adder_chain_ctrl #(
  parameter int N     = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
`ifdef SC_CTRL_SEED_EN
  input  logic [15:0]      seed,
`endif
  input  logic             sum_in,
  output logic [N-2:0]     sel,
  output logic             src_en,
  output logic             flush,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam int          FW       = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      seed_v;
  logic             flush_q, flush_d;
  logic             src_en_q, src_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fb;

`ifdef SC_CTRL_SEED_EN
  logic [15:0] seed_q, seed_d;
  assign seed_v = seed_q;
`else
  assign seed_v = DEF_SEED;
`endif

  // taps 16,14,13,11 -> bits 0,2,3,5 of a right-shifting register
  assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    count_d = count_q;
    lfsr_d  = lfsr_q;
`ifdef SC_CTRL_SEED_EN
    seed_d  = seed_q;
`endif
    if (src_en_q) lfsr_d = {fb, lfsr_q[15:1]};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
`ifdef SC_CTRL_SEED_EN
          seed_d  = (seed == 16'h0) ? DEF_SEED : seed;
`endif
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FLUSH;
            rem_d   = len;
          end
        end
      end
      S_FLUSH: begin
        lfsr_d = seed_v;
        fill_d = FW'(N - 2);
        if (abort)       state_d = S_IDLE;
        else if (N == 2) state_d = S_RUN;
        else             state_d = S_FILL;
      end
      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fill_q == FW'(1)) begin
          state_d = S_RUN;
        end else begin
          fill_d = fill_q - FW'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (sum_in) count_d = count_q + LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_DONE;
          else rem_d = rem_q - LEN_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // outputs are registered from the next state
    flush_d  = (state_d == S_FLUSH);
    src_en_d = (state_d == S_FILL) || (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      lfsr_q   <= DEF_SEED;
      flush_q  <= 1'b0;
      src_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SC_CTRL_SEED_EN
      seed_q   <= DEF_SEED;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
      flush_q  <= flush_d;
      src_en_q <= src_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SC_CTRL_SEED_EN
      seed_q   <= seed_d;
`endif
    end
  end

  for (genvar i = 0; i < N - 1; i++) begin : g_sel
    assign sel[i] = lfsr_q[(5 * i) % 16];
  end

  assign flush  = flush_q;
  assign src_en = src_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign count  = count_q;

endmodule
